// File: rtl/cipher_word_packer_pkg.sv
`default_nettype none
// ============================================================================
// Module   : enc_pkg
// Brief    : Shared types for the ciphertext word packer (byte width, packed
//            word record, pack-state encoding).
// Revision : 1.0 - initial release
// ============================================================================
package enc_pkg;

    localparam int ENC_N    = 8;
    localparam int ENC_PACK = 4;

    typedef struct packed {
        logic [ENC_N*ENC_PACK-1:0] data;
        logic [ENC_PACK-1:0]       keep;
        logic                      last;
    } packed_word_t;

    typedef enum logic [0:0] {
        PK_EMPTY = 1'b0,
        PK_FILL  = 1'b1
    } pk_state_t;

endpackage
`default_nettype wire

// File: rtl/cipher_word_fifo.sv
`default_nettype none
// ============================================================================
// Module   : cipher_word_fifo
// Brief    : DEPTH-entry synchronous FIFO of packed words; head is zero when empty.
// Revision : 1.0 - initial release
// ============================================================================
module cipher_word_fifo
    import enc_pkg::*;
#(
    parameter int WIDTH = $bits(packed_word_t),
    parameter int DEPTH = 4
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         push,
    input  logic                         pop,
    input  logic [WIDTH-1:0]             wdata,
    output logic [WIDTH-1:0]             rdata,
    output logic                         full,
    output logic                         empty,
    output logic [$clog2(DEPTH+1)-1:0]   level
);

    localparam int c_aw = $clog2(DEPTH);
    localparam int c_lw = $clog2(DEPTH+1);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [c_aw-1:0]  r_wr_ptr;
    logic [c_aw-1:0]  r_rd_ptr;
    logic [c_lw-1:0]  r_level;

    // Power-of-two depth lets the pointers wrap naturally.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_level  <= '0;
        end else begin
            if (push) r_wr_ptr <= r_wr_ptr + c_aw'(1);
            if (pop)  r_rd_ptr <= r_rd_ptr + c_aw'(1);
            case ({push, pop})
                2'b10:   r_level <= r_level + c_lw'(1);
                2'b01:   r_level <= r_level - c_lw'(1);
                default: r_level <= r_level;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (push) r_mem[r_wr_ptr] <= wdata;
    end

    assign full  = (r_level == c_lw'(DEPTH));
    assign empty = (r_level == '0);
    assign level = r_level;
    assign rdata = empty ? '0 : r_mem[r_rd_ptr];

endmodule
`default_nettype wire

// File: rtl/cipher_word_packer.sv
`default_nettype none
// ============================================================================
// Module   : cipher_word_packer
// Brief    : Packs PACK ciphertext bytes into words with keep/last, buffered
//            through a DEPTH-entry FIFO onto a word-wide valid/ready output.
// Revision : 1.0 - initial release
// ============================================================================
module cipher_word_packer
    import enc_pkg::*;
#(
    parameter int N     = ENC_N,
    parameter int PACK  = ENC_PACK,
    parameter int DEPTH = 4
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         in_valid,
    output logic                         in_ready,
    input  logic [N-1:0]                 in_data,
    input  logic                         in_last,
    output logic                         out_valid,
    input  logic                         out_ready,
    output logic [N*PACK-1:0]            out_data,
    output logic [PACK-1:0]              out_keep,
    output logic                         out_last,
    output logic [$clog2(DEPTH+1)-1:0]   fifo_level
);

    localparam int c_cw = $clog2(PACK);
    localparam int c_ww = N*PACK + PACK + 1;

    pk_state_t         r_state, w_state_nxt;
    logic [c_cw-1:0]   r_cnt, w_cnt_nxt;
    logic [N*PACK-1:0] r_data, w_data_nxt, w_lane_data;
    logic [PACK-1:0]   r_keep, w_keep_nxt, w_lane_keep;
    logic              w_accept;
    logic              w_push;
    logic              w_pop;
    logic              w_full;
    logic              w_empty;
    logic [c_ww-1:0]   w_head;

    // Gating with rst_n keeps in_ready low while reset is held.
    assign in_ready  = rst_n & ~w_full;
    assign w_accept  = in_valid & in_ready;
    assign out_valid = ~w_empty;
    assign w_pop     = out_valid & out_ready;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= PK_EMPTY;
            r_cnt   <= '0;
            r_data  <= '0;
            r_keep  <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
            r_data  <= w_data_nxt;
            r_keep  <= w_keep_nxt;
        end
    end

    always_comb begin
        w_lane_data                = r_data;
        w_lane_keep                = r_keep;
        w_lane_data[r_cnt*N +: N]  = in_data;
        w_lane_keep[r_cnt]         = 1'b1;
        w_push                     = w_accept & ((r_cnt == c_cw'(PACK-1)) | in_last);
        w_state_nxt                = r_state;
        w_cnt_nxt                  = r_cnt;
        w_data_nxt                 = r_data;
        w_keep_nxt                 = r_keep;
        if (w_accept) begin
            if (w_push) begin
                w_state_nxt = PK_EMPTY;
                w_cnt_nxt   = '0;
                w_data_nxt  = '0;
                w_keep_nxt  = '0;
            end else begin
                w_state_nxt = PK_FILL;
                w_cnt_nxt   = r_cnt + c_cw'(1);
                w_data_nxt  = w_lane_data;
                w_keep_nxt  = w_lane_keep;
            end
        end
    end

    cipher_word_fifo #(
        .WIDTH (c_ww),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rst_n (rst_n),
        .push  (w_push),
        .pop   (w_pop),
        .wdata ({w_lane_data, w_lane_keep, in_last}),
        .rdata (w_head),
        .full  (w_full),
        .empty (w_empty),
        .level (fifo_level)
    );

    assign {out_data, out_keep, out_last} = w_head;

endmodule
`default_nettype wire

// File: tb/tb_cipher_word_packer.sv
`default_nettype none
// ============================================================================
// Module   : tb_cipher_word_packer
// Brief    : Self-checking bench: directed vector table, corner sequences and
//            randomized traffic against a queue-based reference model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_cipher_word_packer;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic [7:0]  in_data;
    logic        in_last;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_data;
    logic [3:0]  out_keep;
    logic        out_last;
    logic [2:0]  fifo_level;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    cipher_word_packer #(.N(8), .PACK(4), .DEPTH(4)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_data    (in_data),
        .in_last    (in_last),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_data   (out_data),
        .out_keep   (out_keep),
        .out_last   (out_last),
        .fifo_level (fifo_level)
    );

    typedef struct {
        logic [7:0]  d;
        logic        l;
        logic        v;
        logic [31:0] ed;
        logic [3:0]  ek;
        logic        el;
    } vec_t;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [7:0] d, input logic l);
        in_valid = 1'b1;
        in_data  = d;
        in_last  = l;
        chk("send_ready", in_ready, 1);
        tick();
        in_valid = 1'b0;
        in_last  = 1'b0;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        tick();
        tick();
        rst_n = 1'b1;
        #1;
    endtask

    // Build the expected packed word from the bytes of one FIFO entry.
    function automatic logic [36:0] make_word(input logic [7:0] b[$], input logic l);
        logic [31:0] d = '0;
        logic [3:0]  k = '0;
        for (int i = 0; i < b.size(); i++) begin
            d[i*8 +: 8] = b[i];
            k[i]        = 1'b1;
        end
        return {d, k, l};
    endfunction

    vec_t        vecs[9];
    logic [36:0] expq[$];
    logic [7:0]  cur[$];
    logic [36:0] got[$];
    logic [7:0]  bl[$];

    initial begin
        rst_n     = 1'b0;
        in_valid  = 1'b0;
        in_data   = '0;
        in_last   = 1'b0;
        out_ready = 1'b0;

        // Outputs while reset is held
        #1;
        chk("rst_in_ready", in_ready, 0);
        chk("rst_out", {out_valid, out_data, out_keep, out_last, fifo_level}, 0);
        tick();
        rst_n = 1'b1;
        #1;
        chk("post_rst_ready", in_ready, 1);
        chk("post_rst_valid", out_valid, 0);
        chk("post_rst_level", fifo_level, 0);
        chk("post_rst_data", out_data, 0);

        // Directed vector table, consumer always ready
        vecs[0] = '{8'h11, 0, 0, 32'h0, 4'h0, 0};
        vecs[1] = '{8'h22, 0, 0, 32'h0, 4'h0, 0};
        vecs[2] = '{8'h33, 0, 0, 32'h0, 4'h0, 0};
        vecs[3] = '{8'h44, 1, 1, 32'h44332211, 4'hF, 1};
        vecs[4] = '{8'hAA, 0, 0, 32'h0, 4'h0, 0};
        vecs[5] = '{8'hBB, 0, 0, 32'h0, 4'h0, 0};
        vecs[6] = '{8'hCC, 1, 1, 32'h00CCBBAA, 4'h7, 1};
        vecs[7] = '{8'h01, 1, 1, 32'h00000001, 4'h1, 1};
        vecs[8] = '{8'h02, 0, 0, 32'h0, 4'h0, 0};
        out_ready = 1'b1;
        foreach (vecs[i]) begin
            in_valid = 1'b1;
            in_data  = vecs[i].d;
            in_last  = vecs[i].l;
            chk("tbl_ready", in_ready, 1);
            tick();
            in_valid = 1'b0;
            in_last  = 1'b0;
            chk("tbl_valid", out_valid, vecs[i].v);
            chk("tbl_word", {out_data, out_keep, out_last},
                vecs[i].v ? {vecs[i].ed, vecs[i].ek, vecs[i].el} : 37'h0);
        end
        send(8'h03, 1'b1);
        chk("tbl_partial2", {out_data, out_keep, out_last}, {32'h00000302, 4'h3, 1'b1});
        tick();
        chk("tbl_drained", fifo_level, 0);

        // Backpressure: fill the FIFO, then drain in order
        do_reset();
        out_ready = 1'b0;
        begin
            int nxt = 1;
            int acc = 0;
            for (int c = 0; c < 40 && acc < 16; c++) begin
                in_valid = 1'b1;
                in_data  = 8'(nxt);
                in_last  = 1'b0;
                if (in_ready) begin
                    acc++;
                    nxt++;
                end
                tick();
            end
            chk("bp_accepted", acc, 16);
            for (int c = 0; c < 3; c++) begin
                in_data = 8'(nxt);
                chk("bp_ready_low", in_ready, 0);
                chk("bp_level_full", fifo_level, 4);
                tick();
            end
            out_ready = 1'b1;
            got.delete();
            for (int c = 0; c < 40 && got.size() < 5; c++) begin
                in_valid = (nxt <= 20);
                in_data  = 8'(nxt);
                in_last  = (nxt == 20);
                if (out_valid) got.push_back({out_data, out_keep, out_last});
                if (in_valid && in_ready) nxt++;
                tick();
            end
            in_valid = 1'b0;
            in_last  = 1'b0;
            chk("bp_word_count", got.size(), 5);
            for (int w = 0; w < 5 && w < got.size(); w++) begin
                bl.delete();
                for (int b = 0; b < 4; b++) bl.push_back(8'(4*w + b + 1));
                chk("bp_word", got[w], make_word(bl, w == 4));
            end
            tick();
            chk("bp_empty", fifo_level, 0);
        end

        // Simultaneous push and pop at level 2
        out_ready = 1'b0;
        send(8'h51, 1'b1);
        send(8'h52, 1'b1);
        chk("pp_level2", fifo_level, 2);
        in_valid  = 1'b1;
        in_data   = 8'h53;
        in_last   = 1'b1;
        out_ready = 1'b1;
        chk("pp_head0", {out_data, out_keep, out_last}, {32'h51, 4'h1, 1'b1});
        tick();
        in_valid = 1'b0;
        in_last  = 1'b0;
        chk("pp_level_same", fifo_level, 2);
        chk("pp_head1", {out_data, out_keep, out_last}, {32'h52, 4'h1, 1'b1});
        tick();
        chk("pp_head2", {out_data, out_keep, out_last}, {32'h53, 4'h1, 1'b1});
        tick();
        chk("pp_empty", {out_valid, fifo_level}, 0);

        // Reset mid-message with buffered words
        out_ready = 1'b0;
        send(8'h61, 1'b1);
        send(8'h62, 1'b1);
        send(8'h63, 1'b1);
        send(8'h64, 1'b0);
        send(8'h65, 1'b0);
        chk("mr_level3", fifo_level, 3);
        #2;
        rst_n = 1'b0;
        #1;
        chk("mr_in_ready", in_ready, 0);
        chk("mr_outs", {out_valid, out_data, out_keep, out_last, fifo_level}, 0);
        tick();
        rst_n = 1'b1;
        #1;
        chk("mr_level0", fifo_level, 0);
        send(8'h77, 1'b1);
        chk("mr_lane0", {out_data, out_keep, out_last, fifo_level}, {32'h77, 4'h1, 1'b1, 3'd1});

        // Randomized traffic against the reference model
        do_reset();
        expq.delete();
        cur.delete();
        for (int c = 0; c < 1200; c++) begin
            logic acc;
            logic pop;
            in_valid  = ($urandom_range(0, 9) < 7);
            in_data   = 8'($urandom);
            in_last   = ($urandom_range(0, 4) == 0);
            out_ready = ((c % 200) < 80) ? ($urandom_range(0, 9) < 2) : ($urandom_range(0, 9) < 7);
            chk("rnd_ready", in_ready, expq.size() < 4);
            chk("rnd_level", fifo_level, expq.size());
            chk("rnd_valid", out_valid, expq.size() > 0);
            chk("rnd_head", {out_data, out_keep, out_last}, expq.size() > 0 ? expq[0] : 37'h0);
            acc = in_valid && (expq.size() < 4);
            pop = out_ready && (expq.size() > 0);
            if (pop) void'(expq.pop_front());
            if (acc) begin
                cur.push_back(in_data);
                if (cur.size() == 4 || in_last) begin
                    expq.push_back(make_word(cur, in_last));
                    cur.delete();
                end
            end
            tick();
        end
        in_valid = 1'b0;

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
